// File: rtl/stream_parity_unit_if.sv
// Handshake bundle for stream_parity_unit: word input channel and frame result channel.
// The master side feeds beats and accepts results; the slave side is the parity unit.
interface stream_parity_unit_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 16
);
    localparam int CNT_W = $clog2(MAX_FRAME + 1);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_par;
    logic              m_valid;
    logic              m_ready;
    logic              m_parity;
    logic              m_error;
    logic [CNT_W-1:0]  m_count;
    logic              m_overflow;

    modport master (
        output s_valid, s_data, s_last, s_par, m_ready,
        input  s_ready, m_valid, m_parity, m_error, m_count, m_overflow
    );

    modport slave (
        input  s_valid, s_data, s_last, s_par, m_ready,
        output s_ready, m_valid, m_parity, m_error, m_count, m_overflow
    );
endinterface

// File: rtl/stream_parity_unit.sv
// Streaming frame parity generator/checker: accumulates XOR over a frame of words,
// then emits one registered result per frame (parity, mismatch, beat count, overflow).
module stream_parity_unit #(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 odd_sel,
    stream_parity_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_FRAME + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t             state, stateNext;
    logic               acc, accNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               modeLat, modeLatNext;
    logic               oddLat, oddLatNext;
    logic               sReadyR, sReadyNext;
    logic               mValidR, mValidNext;
    logic               mParityR, mParityNext;
    logic               mErrorR, mErrorNext;
    logic [CNT_W-1:0]   mCountR, mCountNext;
    logic               mOverflowR, mOverflowNext;

    logic [DATA_W-1:0]  beatData;
    logic               beatPar;
    logic               firstBeat;
    logic               accepted;
    logic [CNT_W-1:0]   cntInc;
    logic               accNew;
    logic               modeEff;
    logic               oddEff;
    logic               forced;
    logic               parNew;

    assign beatData = bus.s_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            modeLat    <= 1'b0;
            oddLat     <= 1'b0;
            sReadyR    <= 1'b0;
            mValidR    <= 1'b0;
            mParityR   <= 1'b0;
            mErrorR    <= 1'b0;
            mCountR    <= '0;
            mOverflowR <= 1'b0;
        end else begin
            state      <= stateNext;
            acc        <= accNext;
            cnt        <= cntNext;
            modeLat    <= modeLatNext;
            oddLat     <= oddLatNext;
            sReadyR    <= sReadyNext;
            mValidR    <= mValidNext;
            mParityR   <= mParityNext;
            mErrorR    <= mErrorNext;
            mCountR    <= mCountNext;
            mOverflowR <= mOverflowNext;
        end
    end

    always_comb begin
        stateNext     = state;
        accNext       = acc;
        cntNext       = cnt;
        modeLatNext   = modeLat;
        oddLatNext    = oddLat;
        sReadyNext    = sReadyR;
        mValidNext    = mValidR;
        mParityNext   = mParityR;
        mErrorNext    = mErrorR;
        mCountNext    = mCountR;
        mOverflowNext = mOverflowR;

        // On the first beat the live mode/odd_sel apply; later beats use the latched copies.
        beatPar   = ^beatData;
        firstBeat = (state == IDLE);
        accepted  = bus.s_valid && sReadyR;
        cntInc    = firstBeat ? CNT_W'(1) : cnt + CNT_W'(1);
        accNew    = firstBeat ? beatPar : (acc ^ beatPar);
        modeEff   = firstBeat ? mode : modeLat;
        oddEff    = firstBeat ? odd_sel : oddLat;
        forced    = !bus.s_last && (cntInc == CNT_W'(MAX_FRAME));
        parNew    = accNew ^ oddEff;

        case (state)
            IDLE, ACCUM: begin
                sReadyNext = 1'b1;
                if (accepted) begin
                    accNext     = accNew;
                    cntNext     = cntInc;
                    modeLatNext = modeEff;
                    oddLatNext  = oddEff;
                    if (bus.s_last || forced) begin
                        stateNext     = RESULT;
                        sReadyNext    = 1'b0;
                        mValidNext    = 1'b1;
                        mParityNext   = parNew;
                        mErrorNext    = modeEff & (parNew != bus.s_par);
                        mCountNext    = cntInc;
                        mOverflowNext = forced;
                    end else begin
                        stateNext = ACCUM;
                    end
                end
            end
            RESULT: begin
                if (bus.m_ready) begin
                    mValidNext = 1'b0;
                    sReadyNext = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.s_ready    = sReadyR;
    assign bus.m_valid    = mValidR;
    assign bus.m_parity   = mParityR;
    assign bus.m_error    = mErrorR;
    assign bus.m_count    = mCountR;
    assign bus.m_overflow = mOverflowR;
endmodule

// File: tb/tb_stream_parity_unit.sv
// Directed bench for stream_parity_unit (DATA_W=8, MAX_FRAME=4) with a frame-level
// reference model and a per-cycle result comparator.
module tb_stream_parity_unit;
    localparam int DW   = 8;
    localparam int MAXF = 4;

    typedef struct {
        bit par;
        bit err;
        int cnt;
        bit ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mode;
    logic odd_sel;

    int errors = 0;
    int checks = 0;

    res_t expQ[$];
    res_t lastRes;
    int   mBeats = 0;
    int   mOnes  = 0;
    bit   mMode  = 1'b0;
    bit   mOdd   = 1'b0;
    int   w;

    stream_parity_unit_if #(.DATA_W(DW), .MAX_FRAME(MAXF)) bus ();

    stream_parity_unit #(.DATA_W(DW), .MAX_FRAME(MAXF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .odd_sel (odd_sel),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level model: count ones, close on s_last or at MAXF beats.
    task automatic modelBeat(input logic [DW-1:0] d, input bit last, input bit par,
                             input bit md, input bit odd);
        res_t r;
        if (mBeats == 0) begin
            mMode = md;
            mOdd  = odd;
            mOnes = 0;
        end
        mBeats++;
        mOnes += $countones(d);
        if (last || mBeats == MAXF) begin
            r.par = ((mOnes % 2) == 1) ^ mOdd;
            r.err = mMode && (r.par != par);
            r.cnt = mBeats;
            r.ovf = !last;
            expQ.push_back(r);
            lastRes = r;
            mBeats  = 0;
        end
    endtask

    task automatic pinRes(input string name, input bit par, input bit err,
                          input int cnt, input bit ovf);
        chk({name, "_model_parity"}, int'(lastRes.par), int'(par));
        chk({name, "_model_error"}, int'(lastRes.err), int'(err));
        chk({name, "_model_count"}, lastRes.cnt, cnt);
        chk({name, "_model_overflow"}, int'(lastRes.ovf), int'(ovf));
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance (or timeout).
    task automatic sendBeat(input logic [DW-1:0] d, input bit last, input bit par,
                            input bit md, input bit odd, output int waits);
        bit rdy;
        bit acc;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_par   = par;
        mode        = md;
        odd_sel     = odd;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 20) begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            if (rdy && rst_n) acc = 1'b1;
            else waits++;
        end
        #1;
        bus.s_valid = 1'b0;
        if (!acc) chk("beat_accept_timeout", waits, 0);
        else modelBeat(d, last, par, md, odd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model front on every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.m_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                chk("spurious_m_valid", int'(bus.m_valid), 0);
            end else begin
                chk("m_parity", int'(bus.m_parity), int'(expQ[0].par));
                chk("m_error", int'(bus.m_error), int'(expQ[0].err));
                chk("m_count", int'(bus.m_count), expQ[0].cnt);
                chk("m_overflow", int'(bus.m_overflow), int'(expQ[0].ovf));
                chk("s_ready_in_result", int'(bus.s_ready), 0);
                if (bus.m_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        mode        = 1'b0;
        odd_sel     = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        bus.s_last  = 1'b1;
        bus.s_par   = 1'b0;
        bus.m_ready = 1'b1;

        // Reset held 3 cycles with s_valid asserted
        repeat (3) begin
            @(negedge clk);
            chk("reset_s_ready", int'(bus.s_ready), 0);
            chk("reset_m_valid", int'(bus.m_valid), 0);
            chk("reset_m_parity", int'(bus.m_parity), 0);
            chk("reset_m_error", int'(bus.m_error), 0);
            chk("reset_m_count", int'(bus.m_count), 0);
            chk("reset_m_overflow", int'(bus.m_overflow), 0);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_before_first_edge", int'(bus.s_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("s_ready_after_release", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        // Generate, even then odd: 0xA5, 0x01
        sendBeat(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, w);
        sendBeat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, w);
        pinRes("gen_even", 1'b1, 1'b0, 2, 1'b0);
        sendBeat(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, w);
        sendBeat(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, w);
        pinRes("gen_odd", 1'b0, 1'b0, 2, 1'b0);

        // Check mode, odd parity, 0xFF single beat
        sendBeat(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, w);
        pinRes("chk_odd_match", 1'b1, 1'b0, 1, 1'b0);
        sendBeat(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, w);
        pinRes("chk_odd_mismatch", 1'b1, 1'b1, 1, 1'b0);

        // Overflow: 5 beats of 0x03, s_last only on the 5th
        for (int i = 0; i < 4; i++) sendBeat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, w);
        pinRes("ovf_first", 1'b0, 1'b0, 4, 1'b1);
        sendBeat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, w);
        pinRes("ovf_second", 1'b0, 1'b0, 1, 1'b0);

        // Backpressure: result held 3 cycles, beat offered in the handshake cycle
        idle(2);
        bus.m_ready = 1'b0;
        sendBeat(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, w);
        pinRes("bp_hold", 1'b1, 1'b0, 1, 1'b0);
        idle(3);
        bus.m_ready = 1'b1;
        sendBeat(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, w);
        chk("handshake_beat_delay", w, 1);
        pinRes("bp_next", 1'b1, 1'b0, 1, 1'b0);

        // Mid-frame mode/odd_sel changes are ignored
        sendBeat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, w);
        sendBeat(8'h02, 1'b0, 1'b0, 1'b1, 1'b1, w);
        sendBeat(8'h04, 1'b1, 1'b0, 1'b1, 1'b1, w);
        pinRes("midframe_toggle", 1'b1, 1'b0, 3, 1'b0);

        // Reset after 2 of 3 beats discards the partial frame
        idle(2);
        sendBeat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, w);
        sendBeat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        mBeats = 0;
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_m_valid", int'(bus.m_valid), 0);
        @(posedge clk);
        #1;
        sendBeat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, w);
        sendBeat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, w);
        sendBeat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, w);
        pinRes("after_reset", 1'b0, 1'b0, 3, 1'b0);

        idle(4);
        chk("results_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
